wishbone_master: RTL and testbench
==================================

# wishbone_master

Wishbone classic-cycle bus initiator: accepts single-word read/write requests on a val/rdy command stream, runs one Wishbone cycle per request, and returns read data or a timeout error on a val/rdy response stream. It is the initiator end of the bus our stream-bridge slave responds on. It lets on-chip test logic or a host-link decoder drive the istream/ostream mailbox (base 0x3000_0000) without the management core. One transaction is outstanding at a time; there is no pipelining.

## Interface
- p_timeout_cycles, 16: max cycles STB is held without ACK before abort; must be ≥1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  request ready.
- req_we  in  1  1 = write, 0 = read.
- req_adr  in  32  byte address.
- req_dat  in  32  write data (ignored for reads).
- req_sel  in  4  byte selects.
- resp_val  out  1  response valid.
- resp_rdy  in  1  response ready.
- resp_dat  out  32  read data; 0 for writes and for errors.
- resp_err  out  1  1 = timed out with no ACK.
- wbm_cyc_o, wbm_stb_o  out  1 each  bus cycle / strobe (always equal).
- wbm_we_o  out  1  write enable.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o  out  32  address.
- wbm_dat_o  out  32  write data.
- wbm_dat_i  in  32  read data from the responder.
- wbm_ack_i  in  1  acknowledge from the responder.

The block has one clock. Reset is synchronous and active-high. Ports are named clk and reset.

## Operation
- FSM states: IDLE, BUS, RESP. Reset puts the FSM in IDLE.
- IDLE
  - req_rdy=1, except it is forced to 0 while reset=1.
  - On req_val&&req_rdy, register we/adr/dat/sel into the wbm_*_o registers, clear the timeout counter, and go to BUS.
- BUS
  - wbm_cyc_o=wbm_stb_o=1. The wbm_*_o fields are held constant.
  - If wbm_ack_i=1:
    - Read: resp_dat<=wbm_dat_i. Write: resp_dat<=0.
    - resp_err<=0. Go to RESP.
  - Else, if the counter equals p_timeout_cycles-1: resp_dat<=0, resp_err<=1, go to RESP.
  - Else, increment the counter.
  - ACK takes priority over timeout in the same cycle.
- RESP
  - resp_val=1, with resp_dat/resp_err held stable.
  - On resp_rdy=1, go to IDLE.
  - req_rdy=0.
- wbm_ack_i is ignored outside BUS.
- wbm_dat_i is sampled only on ACK during a read.
- Counter width is $clog2(p_timeout_cycles+1).
- wbm_adr/dat/sel/we_o keep their last request values after the cycle ends. They are meaningful only while stb=1.

## Timing
- Reset values: wbm_cyc_o, wbm_stb_o, wbm_we_o = 0; wbm_sel_o, wbm_adr_o, wbm_dat_o = 0; resp_val, resp_dat, resp_err = 0. req_rdy=1 on the first cycle after reset deasserts.
- Request accepted at edge 0:
  - STB is high in cycle 1.
  - With a same-cycle (combinational) ACK, resp_val is high in cycle 2.
  - Each cycle of ACK delay adds one cycle.
- Timeout: STB stays high for exactly p_timeout_cycles cycles. resp_val with err=1 rises in the following cycle.
- Best-case throughput is one transaction per 3 cycles, with resp_rdy held at 1 and immediate ACK.
- A response back-pressured by resp_rdy=0 holds RESP indefinitely. The bus stays idle (cyc=0) during that time.
- Reset asserted mid-BUS: cyc/stb go to 0 at that edge. Any pending response is discarded and no resp_val is issued.
- Reset asserted in RESP: resp_val goes to 0 at that edge.

## Test plan
- Reset, then idle: after reset, all outputs equal their reset values and req_rdy=1. With req_val=0 for 10 cycles, cyc and stb stay 0.
- Write with immediate ACK: req we=1, adr=0x3000_0004, dat=0xDEADBEEF, sel=0xF. Required response:
  - Cycle 1: stb=1 with adr/dat/we matching the request.
  - Cycle 2: resp_val=1, resp_dat=0, err=0.
- Read with 3-cycle-delayed ACK: req we=0, adr=0x3000_0010; responder drives dat_i=0x1234_5678 with ACK in cycle 4. Required response: stb high in cycles 1–4, resp_val in cycle 5, resp_dat=0x1234_5678, err=0.
- Timeout: p_timeout_cycles=4, ACK never asserted. Required response: stb high for exactly 4 cycles, then resp_val=1, err=1, resp_dat=0. A subsequent normal read then succeeds.
- ACK on the last allowed cycle: p_timeout_cycles=4, ACK asserted in the 4th STB cycle with dat_i=0xA5A5A5A5. Required response: err=0, resp_dat=0xA5A5A5A5.
- Back-pressure and reset:
  - Hold resp_rdy=0 for 5 cycles: resp_val and resp_dat stay stable, req_rdy=0, cyc=0.
  - Separately, assert reset in cycle 2 of a BUS phase: stb=0 the next cycle, no response is emitted, and req_rdy=1 after reset deasserts.

Source files
------------

// File: rtl/wishbone_master.sv
// Wishbone classic-cycle initiator. It takes one read or write request at a
// time from a val/rdy command stream and runs a single bus cycle for it. It
// then returns the read data, or a timeout error, on a val/rdy response stream.
//
// Handshake semantics (both streams): a transfer happens on a rising edge
// where val and rdy are both 1. The producer holds val and its payload stable
// until that edge. rdy may depend on state and reset but never on val.
module wishbone_master #(
  parameter int p_timeout_cycles = 16
) (
  input  logic        clk,
  input  logic        reset,
  // command stream
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [31:0] req_adr,
  input  logic [31:0] req_dat,
  input  logic [3:0]  req_sel,
  // response stream
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic [31:0] resp_dat,
  output logic        resp_err,
  // wishbone initiator port
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  // FSM state for debug/observation (0=IDLE, 1=BUS, 2=RESP)
  output logic [1:0]  dbg_state
);

  localparam int cnt_w = $clog2(p_timeout_cycles + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(p_timeout_cycles - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [cnt_w-1:0] tmo_cnt;

  // FSM: latch a request, run one bus cycle, and hold the response until it is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      resp_dat  <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val && req_rdy) begin
            wbm_we_o  <= req_we;
            wbm_sel_o <= req_sel;
            wbm_adr_o <= req_adr;
            wbm_dat_o <= req_dat;
            tmo_cnt   <= '0;
            state     <= BUS;
          end
        end
        BUS: begin
          // If ACK and timeout fall in the same cycle, the ACK wins.
          if (wbm_ack_i) begin
            resp_dat <= wbm_we_o ? 32'h0 : wbm_dat_i;
            resp_err <= 1'b0;
            state    <= RESP;
          end else if (tmo_cnt == cnt_last) begin
            resp_dat <= 32'h0;
            resp_err <= 1'b1;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and bus strobes decoded straight from the state register.
  always_comb begin
    req_rdy   = (state == IDLE) && !reset;
    resp_val  = (state == RESP);
    wbm_cyc_o = (state == BUS);
    wbm_stb_o = (state == BUS);
    dbg_state = state;
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed bench for wishbone_master with a 4-cycle timeout. The stimulus sets
// the cycle in which a behavioural responder acknowledges. Inputs are driven
// and outputs sampled 1 time unit after each rising edge.
module tb_wishbone_master;

  localparam int p_timeout = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_val = 1'b0;
  logic        req_rdy;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        resp_val;
  logic        resp_rdy = 1'b1;
  logic [31:0] resp_dat;
  logic        resp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic [1:0]  dbg_state;

  wishbone_master #(.p_timeout_cycles(p_timeout)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we),
    .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
    .resp_val(resp_val), .resp_rdy(resp_rdy),
    .resp_dat(resp_dat), .resp_err(resp_err),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .dbg_state(dbg_state)
  );

  // Responder: it ACKs in STB cycle number ack_at (1-based); 0 means never.
  // Outside an ACK it drives junk data, so mis-sampled data shows up.
  int          ack_at = 0;
  int          stb_cnt = 0;
  logic [31:0] rd_data = '0;
  always @(posedge clk) stb_cnt <= wbm_stb_o ? stb_cnt + 1 : 0;
  assign wbm_ack_i = wbm_stb_o && (ack_at != 0) && (stb_cnt + 1 == ack_at);
  assign wbm_dat_i = wbm_ack_i ? rd_data : 32'hBAD0_BAD0;

  // scoreboard
  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  logic [31:0] cur_dat;
  logic        cur_err;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst_req_rdy_low", req_rdy, 0);
    step();
    reset = 1'b0;
    step();
  endtask

  // Drive one request and follow its bus cycle until STB drops. On return the
  // bench sits in the first cycle after STB, where resp_val should be high.
  task automatic run_txn(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input int ack_cyc, input logic [31:0] rdat,
                         input int exp_stb, input logic exp_err,
                         input logic [31:0] exp_dat);
    int n;
    ack_at  = ack_cyc;
    rd_data = rdat;
    exp_q.push_back(exp_dat);
    exp_err_q.push_back(exp_err);
    check({tag, "_req_rdy"}, req_rdy, 1);
    req_val = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
    step();
    // Scramble the request inputs so held bus fields are really being held.
    req_val = 1'b0; req_we = ~we; req_adr = ~adr; req_dat = ~dat; req_sel = ~sel;
    check({tag, "_req_rdy_busy"}, req_rdy, 0);
    n = 0;
    while (wbm_stb_o && n < 64) begin
      check({tag, "_cyc"}, wbm_cyc_o, 1);
      check({tag, "_adr"}, wbm_adr_o, adr);
      check({tag, "_wdat"}, wbm_dat_o, dat);
      check({tag, "_we"}, wbm_we_o, we);
      check({tag, "_sel"}, wbm_sel_o, sel);
      check({tag, "_resp_val_bus"}, resp_val, 0);
      n++;
      step();
    end
    check({tag, "_stb_cycles"}, n, exp_stb);
    check({tag, "_resp_val"}, resp_val, 1);
    cur_dat = exp_q.pop_front();
    cur_err = exp_err_q.pop_front();
    check({tag, "_resp_dat"}, resp_dat, cur_dat);
    check({tag, "_resp_err"}, resp_err, cur_err);
    check({tag, "_cyc_after"}, wbm_cyc_o, 0);
  endtask

  // Take the response (resp_rdy assumed 1) and confirm the return to idle.
  task automatic finish_resp(input string tag);
    resp_rdy = 1'b1;
    step();
    check({tag, "_resp_val_drop"}, resp_val, 0);
    check({tag, "_req_rdy_back"}, req_rdy, 1);
  endtask

  initial begin
    // Reset, then idle.
    do_reset();
    check("rst_req_rdy", req_rdy, 1);
    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_we", wbm_we_o, 0);
    check("rst_sel", wbm_sel_o, 0);
    check("rst_adr", wbm_adr_o, 0);
    check("rst_wdat", wbm_dat_o, 0);
    check("rst_resp_val", resp_val, 0);
    check("rst_resp_dat", resp_dat, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_state", dbg_state, 0);
    for (int i = 0; i < 10; i++) begin
      check("idle_stb", wbm_stb_o, 0);
      check("idle_cyc", wbm_cyc_o, 0);
      step();
    end

    // Write with immediate ACK; the read data bus must be ignored.
    run_txn("wr_imm", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1, 32'hFFFF_FFFF,
            1, 1'b0, 32'h0);
    finish_resp("wr_imm");

    // Read with the ACK in STB cycle 4 (three cycles of delay).
    run_txn("rd_dly", 1'b0, 32'h3000_0010, 32'h0, 4'hF, 4, 32'h1234_5678,
            4, 1'b0, 32'h1234_5678);
    finish_resp("rd_dly");

    // Timeout with no ACK, then a normal read.
    run_txn("tmo", 1'b0, 32'h3000_0020, 32'h0, 4'h3, 0, 32'h0,
            4, 1'b1, 32'h0);
    finish_resp("tmo");
    run_txn("rd_after_tmo", 1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h0BAD_F00D,
            2, 1'b0, 32'h0BAD_F00D);
    finish_resp("rd_after_tmo");

    // ACK on the last allowed cycle wins over the timeout.
    run_txn("ack_last", 1'b0, 32'h3000_0008, 32'h0, 4'hF, 4, 32'hA5A5_A5A5,
            4, 1'b0, 32'hA5A5_A5A5);
    finish_resp("ack_last");

    // Write with a delayed ACK, sub-word selects.
    run_txn("wr_dly", 1'b1, 32'h3000_000C, 32'h0000_00C3, 4'h1, 2, 32'h7777_7777,
            2, 1'b0, 32'h0);
    finish_resp("wr_dly");

    // Back-pressure: the response holds stable and the bus stays idle.
    resp_rdy = 1'b0;
    run_txn("bp", 1'b0, 32'h3000_0014, 32'h0, 4'hF, 1, 32'h55AA_33CC,
            1, 1'b0, 32'h55AA_33CC);
    req_val = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_resp_val", resp_val, 1);
      check("bp_resp_dat", resp_dat, cur_dat);
      check("bp_resp_err", resp_err, cur_err);
      check("bp_req_rdy", req_rdy, 0);
      check("bp_cyc", wbm_cyc_o, 0);
    end
    req_val = 1'b0;
    finish_resp("bp");

    // Reset in cycle 2 of a BUS phase: no response may come out.
    ack_at = 0;
    req_val = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0030; req_sel = 4'hF;
    step();
    req_val = 1'b0;
    check("rbus_stb_c1", wbm_stb_o, 1);
    step();
    check("rbus_stb_c2", wbm_stb_o, 1);
    reset = 1'b1;
    step();
    check("rbus_stb_off", wbm_stb_o, 0);
    check("rbus_cyc_off", wbm_cyc_o, 0);
    check("rbus_resp_val", resp_val, 0);
    reset = 1'b0;
    step();
    check("rbus_req_rdy", req_rdy, 1);
    for (int i = 0; i < 6; i++) begin
      check("rbus_no_resp", resp_val, 0);
      check("rbus_no_stb", wbm_stb_o, 0);
      step();
    end

    // Reset while a response is held in RESP.
    resp_rdy = 1'b0;
    run_txn("rresp", 1'b0, 32'h3000_0034, 32'h0, 4'hF, 1, 32'h1357_9BDF,
            1, 1'b0, 32'h1357_9BDF);
    reset = 1'b1;
    step();
    check("rresp_val_off", resp_val, 0);
    check("rresp_dat_clr", resp_dat, 0);
    reset = 1'b0;
    resp_rdy = 1'b1;
    step();
    check("rresp_req_rdy", req_rdy, 1);
    check("rresp_no_resp", resp_val, 0);

    // Back-to-back after the reset to confirm normal operation resumes.
    run_txn("post_rst", 1'b1, 32'h3000_0000, 32'hCAFE_0001, 4'hC, 1, 32'h0,
            1, 1'b0, 32'h0);
    finish_resp("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
